// File: rtl/scope_pkg.sv
// Shared constants for the scope capture block: FSM state encoding and trigger edge select.
package scope_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FILL = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_POST = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/scope_capture_if.sv
// Host-side bundle of the scope_capture signals; master = controller/ADC model, slave = capture core.
interface scope_capture_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
);
  logic [DATA_W-1:0] adc_byte;
  logic              adc_clk;
  logic              adc_noe;
  logic              arm;
  logic [DATA_W-1:0] trig_level;
  logic              trig_edge;
  logic [ADDR_W-1:0] post_cnt;
  logic              busy;
  logic              triggered;
  logic              auto_trig;
  logic              done;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output adc_byte, arm, trig_level, trig_edge, post_cnt, rd_en,
    input  adc_clk, adc_noe, busy, triggered, auto_trig, done, rd_data, rd_valid
  );

  modport slave (
    input  adc_byte, arm, trig_level, trig_edge, post_cnt, rd_en,
    output adc_clk, adc_noe, busy, triggered, auto_trig, done, rd_data, rd_valid
  );
endinterface

// File: rtl/scope_ram.sv
// Simple dual-port capture RAM, one write port and one registered read port (block-RAM style).
module scope_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/scope_capture.sv
// Triggered ADC capture into a circular buffer with pre/post-trigger history and read-back.
// Optional build macro SCOPE_AUTO_TRIG_EN forces a trigger after AUTO_TIMEOUT strobes in WAIT.
module scope_capture
  import scope_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 9,
  parameter int CLK_DIV      = 4,
  parameter int AUTO_TIMEOUT = 1024
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic [DATA_W-1:0] iADC_Byte,
  output logic              oADC_CLK,
  output logic              oADC_nOE,
  input  logic              iArm,
  input  logic [DATA_W-1:0] iTrigLevel,
  input  logic              iTrigEdge,
  input  logic [ADDR_W-1:0] iPostCnt,
  output logic              oBusy,
  output logic              oTriggered,
  output logic              oAutoTrig,
  output logic              oDone,
  input  logic              iRdEn,
  output logic [DATA_W-1:0] oRdData,
  output logic              oRdValid
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(DEPTH - 1);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0 || AUTO_TIMEOUT < 1) begin : g_param_check
    $error("scope_capture: CLK_DIV must be even and >= 2, AUTO_TIMEOUT >= 1");
  end

  logic [DIV_W-1:0]  div;
  logic              adc_clk, adc_noe, strb;
  logic [DATA_W-1:0] sample, prev, level_q, ram_q;
  logic              prev_vld, edge_q, triggered, rd_valid;
  logic [2:0]        state;
  logic [ADDR_W-1:0] wr_ptr, post_q;
  logic [CNT_W-1:0]  cnt, rd_cnt, fill_target;
  logic              capturing, we, hit, fire, auto_fire, rd_acc;

  // ADC clock is registered from the divider so it idles low in reset and starts with a high half.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      div     <= '0;
      adc_clk <= 1'b0;
      adc_noe <= 1'b1;
    end else begin
      div     <= (div == DIV_LAST) ? '0 : div + 1'b1;
      adc_clk <= (div < DIV_HALF);
      adc_noe <= 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sample <= '0;
      strb   <= 1'b0;
    end else begin
      strb <= (div == DIV_LAST);
      if (div == DIV_LAST) sample <= iADC_Byte;
    end
  end

  assign capturing   = (state == ST_FILL) || (state == ST_WAIT) || (state == ST_POST);
  assign we          = strb && capturing && !iArm;
  assign fill_target = FILL_MAX - CNT_W'(post_q);
  assign hit         = prev_vld && ((edge_q == EDGE_FALL) ?
                       (prev > level_q && sample <= level_q) :
                       (prev < level_q && sample >= level_q));
  assign fire        = hit || auto_fire;
  assign rd_acc      = (state == ST_DONE) && iRdEn && !iArm && (rd_cnt < CNT_W'(DEPTH));

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      cnt       <= '0;
      rd_cnt    <= '0;
      post_q    <= '0;
      level_q   <= '0;
      edge_q    <= EDGE_RISE;
      prev      <= '0;
      prev_vld  <= 1'b0;
      triggered <= 1'b0;
      rd_valid  <= 1'b0;
    end else if (iArm) begin
      state     <= ST_FILL;
      wr_ptr    <= '0;
      cnt       <= '0;
      rd_cnt    <= '0;
      post_q    <= iPostCnt;
      level_q   <= iTrigLevel;
      edge_q    <= iTrigEdge;
      prev_vld  <= 1'b0;
      triggered <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (we) begin
        wr_ptr   <= wr_ptr + 1'b1;
        prev     <= sample;
        prev_vld <= 1'b1;
      end
      case (state)
        // Exit is checked every cycle so a zero-length fill (PostCnt = DEPTH-1) leaves at once.
        ST_FILL: begin
          if (strb) cnt <= cnt + 1'b1;
          if (cnt + CNT_W'(strb) >= fill_target) state <= ST_WAIT;
        end
        ST_WAIT: if (strb && fire) begin
          triggered <= 1'b1;
          cnt       <= '0;
          state     <= (post_q == '0) ? ST_DONE : ST_POST;
        end
        ST_POST: if (strb) begin
          cnt <= cnt + 1'b1;
          if (cnt + 1'b1 == CNT_W'(post_q)) state <= ST_DONE;
        end
        ST_DONE: if (rd_acc) rd_cnt <= rd_cnt + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SCOPE_AUTO_TRIG_EN
  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  logic            auto_q;

  assign auto_fire = (state == ST_WAIT) && strb && !hit && (to_cnt == TO_W'(AUTO_TIMEOUT - 1));

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      to_cnt <= '0;
      auto_q <= 1'b0;
    end else if (iArm) begin
      to_cnt <= '0;
      auto_q <= 1'b0;
    end else if (state == ST_WAIT && strb) begin
      to_cnt <= to_cnt + 1'b1;
      if (auto_fire) auto_q <= 1'b1;
    end
  end

  assign oAutoTrig = auto_q;
`else
  assign auto_fire = 1'b0;
  assign oAutoTrig = 1'b0;
`endif

  // wr_ptr is frozen in DONE and points at the oldest sample.
  scope_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (iCLK),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (sample),
    .re    (rd_acc),
    .raddr (wr_ptr + rd_cnt[ADDR_W-1:0]),
    .rdata (ram_q)
  );

  assign oADC_CLK   = adc_clk;
  assign oADC_nOE   = adc_noe;
  assign oBusy      = capturing;
  assign oTriggered = triggered;
  assign oDone      = (state == ST_DONE);
  assign oRdValid   = rd_valid;
  assign oRdData    = rd_valid ? ram_q : '0;

endmodule

// File: tb/tb_scope_capture.sv
// Directed bench for scope_capture: ramp captures checked against a buffer-content model.
module tb_scope_capture;
  import scope_pkg::*;

  localparam int DW = 8;
  localparam int AW = 9;
  localparam int DEPTH = 512;
  localparam int CD = 4;

  logic iCLK = 1'b0;
  logic iRST_n = 1'b0;
  always #5 iCLK = ~iCLK;

  scope_capture_if #(.DATA_W(DW), .ADDR_W(AW)) u_if ();

  scope_capture #(.DATA_W(DW), .ADDR_W(AW), .CLK_DIV(CD), .AUTO_TIMEOUT(1024)) dut (
    .iCLK       (iCLK),
    .iRST_n     (iRST_n),
    .iADC_Byte  (u_if.adc_byte),
    .oADC_CLK   (u_if.adc_clk),
    .oADC_nOE   (u_if.adc_noe),
    .iArm       (u_if.arm),
    .iTrigLevel (u_if.trig_level),
    .iTrigEdge  (u_if.trig_edge),
    .iPostCnt   (u_if.post_cnt),
    .oBusy      (u_if.busy),
    .oTriggered (u_if.triggered),
    .oAutoTrig  (u_if.auto_trig),
    .oDone      (u_if.done),
    .iRdEn      (u_if.rd_en),
    .oRdData    (u_if.rd_data),
    .oRdValid   (u_if.rd_valid)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge iCLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ADC source: one value per CD cycles; 0 = hold adc_set, 1 = ramp up, 2 = ramp down
  int         adc_mode = 0;
  logic [7:0] adc_set = 8'h00;
  initial begin
    u_if.adc_byte = 8'h00;
    forever begin
      repeat (CD) @(posedge iCLK);
      #1;
      case (adc_mode)
        1:       u_if.adc_byte = u_if.adc_byte + 8'd1;
        2:       u_if.adc_byte = u_if.adc_byte - 8'd1;
        default: u_if.adc_byte = adc_set;
      endcase
    end
  end

  // Model: a frozen buffer of a ramp is DEPTH consecutive values ending at trigger + step*post
  int         m_last = 0;
  int         m_step = 1;
  int         m_rd = 0;
  bit         m_done = 1'b0;
  int         q_cyc[$];
  logic [7:0] q_dat[$];
  logic [7:0] first_rd, last_rd;
  int         n_rd_seen = 0;
  int         pc;
  logic [7:0] pd;

  function automatic logic [7:0] m_exp(input int i);
    return 8'(m_last + m_step * (i - (DEPTH - 1)));
  endfunction

  always @(negedge iCLK) begin
    if (iRST_n) begin
      if (u_if.rd_valid) begin
        if (q_dat.size() == 0) chk("rd_spurious", 32'd1, 32'd0);
        else begin
          pc = q_cyc.pop_front();
          pd = q_dat.pop_front();
          chk("rd_latency", cyc, pc + 1);
          chk("rd_data", u_if.rd_data, pd);
          if (n_rd_seen == 0) first_rd = u_if.rd_data;
          last_rd = u_if.rd_data;
          n_rd_seen++;
        end
      end else if (q_cyc.size() > 0 && cyc > q_cyc[0]) begin
        chk("rd_missing", 32'd0, 32'd1);
        pc = q_cyc.pop_front();
        pd = q_dat.pop_front();
      end
    end
  end

  task automatic rd_burst(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge iCLK); #1;
      u_if.rd_en = 1'b1;
      if (m_done && m_rd < DEPTH) begin
        q_cyc.push_back(cyc);
        q_dat.push_back(m_exp(m_rd));
        m_rd++;
      end
    end
    @(posedge iCLK); #1;
    u_if.rd_en = 1'b0;
    repeat (2) @(posedge iCLK);
    chk("rd_drain", q_dat.size(), 32'd0);
  endtask

  task automatic arm(input logic [8:0] post, input logic [7:0] lvl, input logic edg, input bit with_rd);
    @(posedge iCLK); #1;
    u_if.arm = 1'b1;
    u_if.rd_en = with_rd;
    u_if.post_cnt = post;
    u_if.trig_level = lvl;
    u_if.trig_edge = edg;
    m_done = 1'b0;
    m_rd = 0;
    @(posedge iCLK); #1;
    u_if.arm = 1'b0;
    u_if.rd_en = 1'b0;
    n_rd_seen = 0;
  endtask

  task automatic wait_capture(input int budget, output int t_trig, output int t_done);
    t_trig = -1;
    t_done = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge iCLK);
      if (u_if.triggered && t_trig < 0) t_trig = cyc;
      if (u_if.done) begin
        t_done = cyc;
        break;
      end
    end
    if (t_done < 0) chk("capture_timeout", 32'd0, 32'd1);
    else m_done = 1'b1;
  endtask

  task automatic run_ramp(input string tag, input int post, input logic [7:0] first_exp,
                          input logic [7:0] last_exp);
    int tt, td;
    wait_capture(8000, tt, td);
    chk({tag, "_post_latency"}, td - tt, post * CD);
    chk({tag, "_triggered"}, u_if.triggered, 32'd1);
    chk({tag, "_auto"}, u_if.auto_trig, 32'd0);
    chk({tag, "_busy"}, u_if.busy, 32'd0);
    rd_burst(DEPTH + 2);
    chk({tag, "_nreads"}, n_rd_seen, DEPTH);
    chk({tag, "_first"}, first_rd, first_exp);
    chk({tag, "_last"}, last_rd, last_exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat;
    int t;
    int tt, td;
    u_if.arm = 1'b0;
    u_if.rd_en = 1'b0;
    u_if.post_cnt = '0;
    u_if.trig_level = '0;
    u_if.trig_edge = EDGE_RISE;

    repeat (3) @(negedge iCLK);
    chk("rst_adc_clk", u_if.adc_clk, 32'd0);
    chk("rst_noe", u_if.adc_noe, 32'd1);
    chk("rst_busy", u_if.busy, 32'd0);
    chk("rst_trig", u_if.triggered, 32'd0);
    chk("rst_auto", u_if.auto_trig, 32'd0);
    chk("rst_done", u_if.done, 32'd0);
    chk("rst_rdvalid", u_if.rd_valid, 32'd0);
    chk("rst_rddata", u_if.rd_data, 32'd0);

    // divider: two cycles high, two low, starting right after reset
    iRST_n = 1'b1;
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge iCLK);
      pat = {pat[6:0], u_if.adc_clk};
    end
    chk("adc_clk_pattern", pat, 8'b1100_1100);
    chk("noe_running", u_if.adc_noe, 32'd0);
    rd_burst(3);

    // rising ramp, level 0x80, 16 post samples
    adc_mode = 1;
    arm(9'd16, 8'h80, EDGE_RISE, 1'b0);
    rd_burst(4);
    m_last = 8'h80 + 16; m_step = 1;
    run_ramp("rise", 16, 8'h91, 8'h90);

    // falling ramp; arm collides with a read request, arm wins
    adc_mode = 2;
    arm(9'd8, 8'h40, EDGE_FALL, 1'b1);
    @(negedge iCLK);
    chk("arm_over_rd_done", u_if.done, 32'd0);
    chk("arm_over_rd_busy", u_if.busy, 32'd1);
    m_last = 8'h40 - 8; m_step = -1;
    run_ramp("fall", 8, 8'h37, 8'h38);

    // PostCnt = 0: trigger sample is the newest entry
    adc_mode = 1;
    arm(9'd0, 8'h80, EDGE_RISE, 1'b0);
    m_last = 8'h80; m_step = 1;
    run_ramp("post0", 0, 8'h81, 8'h80);

    // step through the level during the short FILL only; never a trigger afterwards
    adc_mode = 0;
    adc_set = 8'h00;
    arm(9'd500, 8'h80, EDGE_RISE, 1'b0);
    repeat (2 * CD) @(posedge iCLK);
    adc_set = 8'h90;
    repeat (400) @(posedge iCLK);
    @(negedge iCLK);
    chk("fill_trig_ignored", u_if.triggered, 32'd0);
    chk("fill_still_busy", u_if.busy, 32'd1);
    chk("fill_not_done", u_if.done, 32'd0);

    // reset pulse while in WAIT
    iRST_n = 1'b0;
    #1;
    chk("wait_rst_busy", u_if.busy, 32'd0);
    chk("wait_rst_trig", u_if.triggered, 32'd0);
    chk("wait_rst_done", u_if.done, 32'd0);
    chk("wait_rst_noe", u_if.adc_noe, 32'd1);
    chk("wait_rst_adc_clk", u_if.adc_clk, 32'd0);
    @(negedge iCLK);
    iRST_n = 1'b1;
    @(negedge iCLK);
    chk("post_rst_idle", u_if.busy, 32'd0);
    chk("post_rst_done", u_if.done, 32'd0);
    chk("post_rst_noe", u_if.adc_noe, 32'd0);

    // constant input: never crosses the level
    adc_set = 8'h10;
    arm(9'd4, 8'h80, EDGE_RISE, 1'b0);
`ifdef SCOPE_AUTO_TRIG_EN
    wait_capture(9000, tt, td);
    chk("auto_flag", u_if.auto_trig, 32'd1);
    chk("auto_triggered", u_if.triggered, 32'd1);
`else
    repeat (1100 * CD) @(posedge iCLK);
    @(negedge iCLK);
    chk("noauto_busy", u_if.busy, 32'd1);
    chk("noauto_trig", u_if.triggered, 32'd0);
    chk("noauto_flag", u_if.auto_trig, 32'd0);
`endif

    // re-arm in the middle of a long POST
    adc_mode = 1;
    arm(9'd200, 8'h80, EDGE_RISE, 1'b0);
    t = -1;
    for (int k = 0; k < 6000; k++) begin
      @(negedge iCLK);
      if (u_if.triggered) begin
        t = k;
        break;
      end
    end
    chk("post_phase_trig_seen", (t >= 0), 32'd1);
    repeat (40) @(negedge iCLK);
    chk("in_post_busy", u_if.busy, 32'd1);
    chk("in_post_done", u_if.done, 32'd0);
    arm(9'd16, 8'h80, EDGE_RISE, 1'b0);
    @(negedge iCLK);
    chk("rearm_trig_clr", u_if.triggered, 32'd0);
    chk("rearm_busy", u_if.busy, 32'd1);
    chk("rearm_done", u_if.done, 32'd0);
    chk("rearm_auto", u_if.auto_trig, 32'd0);
    m_last = 8'h80 + 16; m_step = 1;
    run_ramp("rearm", 16, 8'h91, 8'h90);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
